// File: rtl/display_3bits_counter_ctrl.sv
// Run/pause/clear controller for a 3-bit up/down counter feeding a 7-segment digit.
// Two debounced buttons drive a prescaled counting FSM; segments decode the count.
module display_3bits_counter_ctrl #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter bit          WRAP     = 1'b1
) (
    input  logic       input_clock1_1,
    input  logic       input_reset1_2,
    input  logic       input_btn_run_3,
    input  logic       input_btn_clear_4,
    input  logic       input_dir_5,
    output logic [2:0] output_count_6,
    output logic [1:0] output_state_7,
    output logic       output_tc_8,
    output logic [6:0] output_seg_9,
    output logic       output_dp_10
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned NB = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // button index 0 = run, 1 = clear
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [DW-1:0] btn_cnt [NB];

    state_t        state_q;
    state_t        state_nxt;
    logic [2:0]    count_q;
    logic [2:0]    count_nxt;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_nxt;
    logic          tc_q;
    logic          tc_nxt;
    logic          at_end;

    assign btn_raw = {input_btn_clear_4, input_btn_run_3};

    // Level flips only after DEBOUNCE consecutive disagreeing samples; press marks 0->1 flips.
    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < NB; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                btn_press[i] <= 1'b0;
                if (btn_raw[i] != btn_level[i]) begin
                    if (btn_cnt[i] == DW'(DEBOUNCE - 1)) begin
                        btn_level[i] <= btn_raw[i];
                        btn_press[i] <= btn_raw[i];
                        btn_cnt[i]   <= '0;
                    end else begin
                        btn_cnt[i] <= btn_cnt[i] + DW'(1);
                    end
                end else begin
                    btn_cnt[i] <= '0;
                end
            end
        end
    end

    // State register together with the datapath registers it sequences.
    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            presc_q <= presc_nxt;
            tc_q    <= tc_nxt;
        end
    end

    assign at_end = input_dir_5 ? (count_q == 3'd7) : (count_q == 3'd0);

    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        presc_nxt = presc_q;
        tc_nxt    = 1'b0;
        if (btn_press[1]) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (btn_press[0]) begin
                        state_nxt = ST_RUN;
                        presc_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_nxt = '0;
                        tc_nxt    = at_end;
                        if (at_end && !WRAP) begin
                            state_nxt = ST_DONE;
                        end else begin
                            count_nxt = input_dir_5 ? (count_q + 3'd1) : (count_q - 3'd1);
                        end
                    end else begin
                        presc_nxt = presc_q + PW'(1);
                    end
                    // a pause coinciding with a step still takes the step
                    if (btn_press[0] && state_nxt == ST_RUN) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (btn_press[0]) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
            endcase
        end
    end

    // Output decode: segments {g,f,e,d,c,b,a} and RUN indicator.
    always_comb begin
        output_seg_9 = 7'b0111111;
        output_dp_10 = (state_q == ST_RUN);
        unique case (count_q)
            3'd0: output_seg_9 = 7'b0111111;
            3'd1: output_seg_9 = 7'b0000110;
            3'd2: output_seg_9 = 7'b1011011;
            3'd3: output_seg_9 = 7'b1001111;
            3'd4: output_seg_9 = 7'b1100110;
            3'd5: output_seg_9 = 7'b1101101;
            3'd6: output_seg_9 = 7'b1111101;
            3'd7: output_seg_9 = 7'b0000111;
        endcase
    end

    assign output_count_6 = count_q;
    assign output_state_7 = state_q;
    assign output_tc_8    = tc_q;

endmodule

// File: tb/tb_display_3bits_counter_ctrl.sv
// Directed bench: one instance with wrap enabled, one with wrap disabled.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_display_3bits_counter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst0, run, clr, dir;
    logic [2:0] cnt1, cnt0;
    logic [1:0] st1, st0;
    logic       tc1, tc0, dp1, dp0;
    logic [6:0] seg1, seg0;

    int errors = 0;
    int checks = 0;

    display_3bits_counter_ctrl #(.PRESCALE(4), .DEBOUNCE(3), .WRAP(1'b1)) u_wrap (
        .input_clock1_1   (clk),
        .input_reset1_2   (rst1),
        .input_btn_run_3  (run),
        .input_btn_clear_4(clr),
        .input_dir_5      (dir),
        .output_count_6   (cnt1),
        .output_state_7   (st1),
        .output_tc_8      (tc1),
        .output_seg_9     (seg1),
        .output_dp_10     (dp1)
    );

    display_3bits_counter_ctrl #(.PRESCALE(4), .DEBOUNCE(3), .WRAP(1'b0)) u_stop (
        .input_clock1_1   (clk),
        .input_reset1_2   (rst0),
        .input_btn_run_3  (run),
        .input_btn_clear_4(clr),
        .input_dir_5      (dir),
        .output_count_6   (cnt0),
        .output_state_7   (st0),
        .output_tc_8      (tc0),
        .output_seg_9     (seg0),
        .output_dp_10     (dp0)
    );

    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;

    typedef struct {
        bit         rst;
        bit         run;
        bit         clr;
        bit         dir;
        int         reps;
        logic [2:0] cnt;
        logic [1:0] st;
        bit         tc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] seg_of(input logic [2:0] d);
        case (d)
            3'd0: return 7'b0111111;
            3'd1: return 7'b0000110;
            3'd2: return 7'b1011011;
            3'd3: return 7'b1001111;
            3'd4: return 7'b1100110;
            3'd5: return 7'b1101101;
            3'd6: return 7'b1111101;
            default: return 7'b0000111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input bit stop, input string nm, input logic [2:0] ec,
                           input logic [1:0] es, input logic et);
        logic [2:0] c;
        logic [1:0] s;
        logic       t, p;
        logic [6:0] g;
        c = stop ? cnt0 : cnt1;
        s = stop ? st0  : st1;
        t = stop ? tc0  : tc1;
        p = stop ? dp0  : dp1;
        g = stop ? seg0 : seg1;
        chk({nm, ".count"}, 32'(c), 32'(ec));
        chk({nm, ".state"}, 32'(s), 32'(es));
        chk({nm, ".tc"},    32'(t), 32'(et));
        chk({nm, ".dp"},    32'(p), 32'(es == RUN));
        chk({nm, ".seg"},   32'(g), 32'(seg_of(ec)));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw button held across three sampling edges; returns with the press pulse pending.
    task automatic hold_run();
        run = 1'b1;
        cyc(3);
        run = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1; rst0 = 1'b1; run = 1'b0; clr = 1'b0; dir = 1'b1;
        @(negedge clk);

        //            rst run clr dir reps cnt   st     tc
        tbl.push_back('{1, 0, 0, 1,  2, 3'd0, IDLE,  0});
        tbl.push_back('{0, 0, 0, 1, 20, 3'd0, IDLE,  0});
        tbl.push_back('{0, 1, 0, 1,  2, 3'd0, IDLE,  0});  // 2-cycle glitch
        tbl.push_back('{0, 0, 0, 1,  4, 3'd0, IDLE,  0});
        tbl.push_back('{0, 1, 0, 1,  3, 3'd0, IDLE,  0});  // third stable edge accepts
        tbl.push_back('{0, 1, 0, 1,  1, 3'd0, RUN,   0});
        tbl.push_back('{0, 1, 0, 1,  2, 3'd0, RUN,   0});  // still held: single press
        tbl.push_back('{0, 0, 0, 1,  1, 3'd0, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd1, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd2, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd3, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd4, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd5, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd6, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  4, 3'd7, RUN,   0});
        tbl.push_back('{0, 0, 0, 1,  1, 3'd0, RUN,   1});  // up wrap 7->0
        tbl.push_back('{0, 0, 0, 1,  1, 3'd0, RUN,   0});
        tbl.push_back('{0, 0, 0, 0,  2, 3'd0, RUN,   0});  // dir change waits for step
        tbl.push_back('{0, 0, 0, 0,  1, 3'd7, RUN,   1});  // down wrap 0->7
        tbl.push_back('{0, 0, 0, 0,  1, 3'd7, RUN,   0});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                rst1 = tbl[i].rst; run = tbl[i].run; clr = tbl[i].clr; dir = tbl[i].dir;
                @(negedge clk);
                chk_dut(1'b0, $sformatf("vec%0d.%0d", i, r), tbl[i].cnt, tbl[i].st, tbl[i].tc);
            end
        end
        chk_dut(1'b1, "stop_in_reset", 3'd0, IDLE, 1'b0);

        // Pause with prescaler frozen at 2, resume, then clear+run together.
        rst1 = 1'b1; run = 1'b0; clr = 1'b0; dir = 1'b1;
        cyc(2);
        rst1 = 1'b0;
        hold_run();
        cyc(1); chk_dut(1'b0, "A_run", 3'd0, RUN, 1'b0);
        cyc(2);
        hold_run();
        chk_dut(1'b0, "A_pre_pause", 3'd1, RUN, 1'b0);
        cyc(1); chk_dut(1'b0, "A_pause", 3'd1, PAUSE, 1'b0);
        cyc(6); chk_dut(1'b0, "A_frozen", 3'd1, PAUSE, 1'b0);
        hold_run();
        cyc(1); chk_dut(1'b0, "A_resume", 3'd1, RUN, 1'b0);
        cyc(1); chk_dut(1'b0, "A_resume1", 3'd1, RUN, 1'b0);
        cyc(1); chk_dut(1'b0, "A_step", 3'd2, RUN, 1'b0);
        run = 1'b1; clr = 1'b1;
        cyc(3);
        chk_dut(1'b0, "A_before_clr", 3'd2, RUN, 1'b0);
        run = 1'b0; clr = 1'b0;
        cyc(1); chk_dut(1'b0, "A_clear", 3'd0, IDLE, 1'b0);
        cyc(5); chk_dut(1'b0, "A_idle_after", 3'd0, IDLE, 1'b0);

        // Reset in the middle of RUN at count 5, with the run button active.
        rst1 = 1'b1;
        cyc(1);
        rst1 = 1'b0;
        hold_run();
        cyc(1);  chk_dut(1'b0, "B_run", 3'd0, RUN, 1'b0);
        cyc(20); chk_dut(1'b0, "B_cnt5", 3'd5, RUN, 1'b0);
        rst1 = 1'b1; run = 1'b1;
        cyc(1); chk_dut(1'b0, "B_reset", 3'd0, IDLE, 1'b0);
        cyc(3); chk_dut(1'b0, "B_reset_hold", 3'd0, IDLE, 1'b0);
        run = 1'b0;

        // Non-wrapping instance: down-count into DONE, run ignored, clear recovers.
        dir = 1'b1;
        cyc(1);
        rst0 = 1'b0;
        hold_run();
        cyc(1); chk_dut(1'b1, "C_run", 3'd0, RUN, 1'b0);
        cyc(4); chk_dut(1'b1, "C_up1", 3'd1, RUN, 1'b0);
        dir = 1'b0;
        cyc(4); chk_dut(1'b1, "C_down0", 3'd0, RUN, 1'b0);
        cyc(3); chk_dut(1'b1, "C_pre_done", 3'd0, RUN, 1'b0);
        cyc(1); chk_dut(1'b1, "C_done", 3'd0, DONE, 1'b1);
        cyc(1); chk_dut(1'b1, "C_done_tc_off", 3'd0, DONE, 1'b0);
        hold_run();
        cyc(1); chk_dut(1'b1, "C_run_ignored", 3'd0, DONE, 1'b0);
        cyc(6); chk_dut(1'b1, "C_done_hold", 3'd0, DONE, 1'b0);
        clr = 1'b1;
        cyc(3);
        clr = 1'b0;
        cyc(1); chk_dut(1'b1, "C_clear", 3'd0, IDLE, 1'b0);
        chk_dut(1'b0, "C_wrap_in_reset", 3'd0, IDLE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
